clk_period_meter: RTL and testbench

//   Measures the period of a slow clock-like signal, such as a divided clock, against the system clock.
//   On a start pulse it captures NUM_PERIODS consecutive rising-edge-to-rising-edge periods.
//   It reports the sum, minimum and maximum period in clk cycles.

---
 rtl/clk_period_meter_pkg.sv | 34 +++
 rtl/sync_edge_det.sv | 38 +++
 rtl/clk_period_meter.sv | 199 +++++++++++++++++++
 tb/tb_clk_period_meter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_period_meter_pkg.sv
// -----------------------------------------------------------------------------
// clk_period_meter_pkg
//   Shared definitions for the clock period meter: FSM state encoding,
//   default parameter values and a constant helper for sizing counters.
// -----------------------------------------------------------------------------
package clk_period_meter_pkg;

    // Measurement run FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // waiting for start
        ST_ARM  = 2'd1,  // waiting for the reference edge
        ST_MEAS = 2'd2,  // timing consecutive periods
        ST_FIN  = 2'd3   // one-cycle done
    } state_e;

    // Default timeout: one second of the 50 MHz base clock.
    localparam int unsigned DEFAULT_TIMEOUT_CYC = 50_000_000;
    localparam int unsigned DEFAULT_CNT_W       = 32;
    localparam int unsigned DEFAULT_NUM_PERIODS = 4;

    // Width of the completed-period counter; NUM_PERIODS is limited to 1..15.
    localparam int unsigned N_W = 4;

    // Number of bits needed to hold max_val (at least 1).
    function automatic int unsigned bits_for(input longint unsigned max_val);
        int unsigned w;
        w = 1;
        for (int i = 1; i < 64; i++) begin
            if ((max_val >> i) != 0) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
//   Two-flop synchroniser for an asynchronous input followed by a registered
//   rising-edge detector. edge_p is a one-cycle pulse appearing three clk
//   cycles after the input rises.
//
// Ports
//   clk          in   system clock, rising edge
//   clk_reset_n  in   asynchronous active-low reset
//   sig_in       in   asynchronous input
//   edge_p       out  one-cycle rising-edge pulse in the clk domain
// -----------------------------------------------------------------------------
module sync_edge_det (
    input  logic clk,
    input  logic clk_reset_n,
    input  logic sig_in,
    output logic edge_p
);

    // [0],[1]: synchroniser stages; [2]: previous synchronised value.
    logic [2:0] sync_q;
    logic       edge_q;

    // NOTE: clocked state always uses non-blocking assignments so every
    // flop samples the pre-edge value of its neighbour, as the hardware does.
    always_ff @(posedge clk or negedge clk_reset_n) begin
        if (!clk_reset_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], sig_in};
            edge_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign edge_p = edge_q;

endmodule

// File: rtl/clk_period_meter.sv
// -----------------------------------------------------------------------------
// clk_period_meter
//   Measures NUM_PERIODS consecutive rising-edge-to-rising-edge periods of a
//   slow, asynchronous signal in clk cycles and reports their saturating sum,
//   minimum and maximum. A run aborts with timeout if no rising edge arrives
//   within TIMEOUT_CYC cycles.
//
// Ports
//   clk          in   system clock, rising edge
//   clk_reset_n  in   asynchronous active-low reset
//   sig_in       in   measured signal, asynchronous to clk
//   start        in   one-cycle pulse; arms a run when not busy
//   busy         out  high from the cycle after an accepted start until done
//   done         out  one-cycle pulse at the end of a run
//   timeout      out  run ended by timeout; held until the next accepted start
//   period_sum   out  saturating sum of completed periods; held
//   period_min   out  smallest completed period (all-ones if none); held
//   period_max   out  largest completed period (zero if none); held
// -----------------------------------------------------------------------------
module clk_period_meter
    import clk_period_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = DEFAULT_CNT_W,
    parameter int unsigned NUM_PERIODS = DEFAULT_NUM_PERIODS,
    parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic             clk,
    input  logic             clk_reset_n,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] period_sum,
    output logic [CNT_W-1:0] period_min,
    output logic [CNT_W-1:0] period_max
);

    // The timeout timer is sized from TIMEOUT_CYC rather than CNT_W so that a
    // narrow result width never weakens the timeout.
    localparam int unsigned          TMO_W    = bits_for(longint'(TIMEOUT_CYC) - 1);
    localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [N_W-1:0]       N_LAST   = N_W'(NUM_PERIODS - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX  = '1;

    state_e           state_q, state_d;
    logic             edge_p;

    logic [CNT_W-1:0] per_cnt_q;   // cycles since the last edge, minus one
    logic [TMO_W-1:0] tmo_cnt_q;   // cycles without an edge, minus one
    logic [N_W-1:0]   n_q;         // completed periods this run
    logic [CNT_W-1:0] sum_q, min_q, max_q;
    logic             timeout_q;

    logic             accept;      // start accepted this cycle
    logic             take;        // a period completes this cycle
    logic             abort;       // run ends by timeout this cycle
    logic             counting;
    logic             tmo_hit;
    logic [CNT_W-1:0] period_val;
    logic [CNT_W:0]   sum_wide;
    logic [CNT_W-1:0] sum_next;

    // -------------------------------------------------------------------------
    // Input path
    // -------------------------------------------------------------------------
    sync_edge_det u_sync_edge_det (
        .clk         (clk),
        .clk_reset_n (clk_reset_n),
        .sig_in      (sig_in),
        .edge_p      (edge_p)
    );

    // -------------------------------------------------------------------------
    // Datapath helpers
    // -------------------------------------------------------------------------
    assign counting = (state_q == ST_ARM) || (state_q == ST_MEAS);
    assign tmo_hit  = (tmo_cnt_q == TMO_LAST);

    // per_cnt holds (cycles since edge - 1); the period is one more, except
    // when the counter has saturated, where the period is clamped instead.
    assign period_val = (per_cnt_q == CNT_MAX) ? CNT_MAX : per_cnt_q + CNT_W'(1);

    assign sum_wide = {1'b0, sum_q} + {1'b0, period_val};
    assign sum_next = sum_wide[CNT_W] ? CNT_MAX : sum_wide[CNT_W-1:0];

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clk_reset_n) begin
        if (!clk_reset_n) state_q <= ST_IDLE;
        else              state_q <= state_d;
    end

    // NOTE: every output of this block gets a default before the case, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        take    = 1'b0;
        abort   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ARM;
                    accept  = 1'b1;
                end
            end
            ST_ARM: begin
                // An edge arriving on the last allowed cycle still counts.
                if (edge_p) begin
                    state_d = ST_MEAS;
                end else if (tmo_hit) begin
                    state_d = ST_FIN;
                    abort   = 1'b1;
                end
            end
            ST_MEAS: begin
                if (edge_p) begin
                    take = 1'b1;
                    if (n_q == N_LAST) state_d = ST_FIN;
                end else if (tmo_hit) begin
                    state_d = ST_FIN;
                    abort   = 1'b1;
                end
            end
            ST_FIN: begin
                // A start coinciding with done begins the next run directly.
                if (start) begin
                    state_d = ST_ARM;
                    accept  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Period and timeout counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clk_reset_n) begin
        if (!clk_reset_n) begin
            per_cnt_q <= '0;
            tmo_cnt_q <= '0;
        end else if (accept) begin
            per_cnt_q <= '0;
            tmo_cnt_q <= '0;
        end else if (counting) begin
            if (edge_p) begin
                per_cnt_q <= '0;
                tmo_cnt_q <= '0;
            end else begin
                if (per_cnt_q != CNT_MAX) per_cnt_q <= per_cnt_q + CNT_W'(1);
                if (!tmo_hit)             tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Results
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clk_reset_n) begin
        if (!clk_reset_n) begin
            n_q       <= '0;
            sum_q     <= '0;
            min_q     <= CNT_MAX;
            max_q     <= '0;
            timeout_q <= 1'b0;
        end else if (accept) begin
            n_q       <= '0;
            sum_q     <= '0;
            min_q     <= CNT_MAX;
            max_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (take) begin
                n_q   <= n_q + N_W'(1);
                sum_q <= sum_next;
                // Strict comparisons: an equal period leaves the value alone.
                if (period_val < min_q) min_q <= period_val;
                if (period_val > max_q) max_q <= period_val;
            end
            if (abort) timeout_q <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy       = counting;
    assign done       = (state_q == ST_FIN);
    assign timeout    = timeout_q;
    assign period_sum = sum_q;
    assign period_min = min_q;
    assign period_max = max_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// -----------------------------------------------------------------------------
// tb_clk_period_meter
//   Self-checking bench for clk_period_meter. Two instances: a 32-bit one with
//   a 100-cycle timeout and an 8-bit one with a 1000-cycle timeout. Stimulus
//   is a list of periods turned into a sig_in waveform; expected results come
//   from a list-level model of the measurement rules.
// -----------------------------------------------------------------------------
module tb_clk_period_meter;

    localparam int NUM   = 4;
    localparam int TMO_A = 100;
    localparam int TMO_B = 1000;
    localparam int W_A   = 32;
    localparam int W_B   = 8;

    logic           clk = 1'b0;
    logic           clk_reset_n;
    logic           sig_a, start_a, sig_b, start_b;
    logic           busy_a, done_a, timeout_a;
    logic           busy_b, done_b, timeout_b;
    logic [W_A-1:0] sum_a, min_a, max_a;
    logic [W_B-1:0] sum_b, min_b, max_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    clk_period_meter #(.CNT_W(W_A), .NUM_PERIODS(NUM), .TIMEOUT_CYC(TMO_A)) dut_a (
        .clk(clk), .clk_reset_n(clk_reset_n), .sig_in(sig_a), .start(start_a),
        .busy(busy_a), .done(done_a), .timeout(timeout_a),
        .period_sum(sum_a), .period_min(min_a), .period_max(max_a)
    );

    clk_period_meter #(.CNT_W(W_B), .NUM_PERIODS(NUM), .TIMEOUT_CYC(TMO_B)) dut_b (
        .clk(clk), .clk_reset_n(clk_reset_n), .sig_in(sig_b), .start(start_b),
        .busy(busy_b), .done(done_b), .timeout(timeout_b),
        .period_sum(sum_b), .period_min(min_b), .period_max(max_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] all_ones(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    task automatic drive(input int sel, input logic s, input logic st);
        if (sel == 0) begin sig_a = s; start_a = st; end
        else          begin sig_b = s; start_b = st; end
    endtask

    task automatic sample(input int sel, output logic o_busy, output logic o_done,
                          output logic o_tmo, output logic [63:0] o_sum,
                          output logic [63:0] o_min, output logic [63:0] o_max);
        if (sel == 0) begin
            o_busy = busy_a; o_done = done_a; o_tmo = timeout_a;
            o_sum = 64'(sum_a); o_min = 64'(min_a); o_max = 64'(max_a);
        end else begin
            o_busy = busy_b; o_done = done_b; o_tmo = timeout_b;
            o_sum = 64'(sum_b); o_min = 64'(min_b); o_max = 64'(max_b);
        end
    endtask

    // Expected results of a run whose rising edges are separated by per_q:
    // the first NUM periods count unless one exceeds the timeout limit, in
    // which case only the periods before it count and the run times out.
    task automatic model(input int per_q[$], input int w, input int limit,
                         output logic [63:0] e_sum, output logic [63:0] e_min,
                         output logic [63:0] e_max, output logic e_tmo);
        longint s;
        e_min = all_ones(w);
        e_max = 0;
        e_tmo = 1'b0;
        s     = 0;
        for (int i = 0; i < NUM; i++) begin
            if (i >= per_q.size() || per_q[i] > limit) begin
                e_tmo = 1'b1;
                break;
            end
            s = s + per_q[i];
            if (s > longint'(all_ones(w))) s = longint'(all_ones(w));
            if (per_q[i] < e_min) e_min = 64'(per_q[i]);
            if (per_q[i] > e_max) e_max = 64'(per_q[i]);
        end
        e_sum = 64'(s);
    endtask

    // One measurement run. sig_in rises after 'lead' low cycles, then once per
    // listed period (high for half the period). done_cyc is the number of clk
    // edges from the edge that samples start to the edge that raises done.
    task automatic measure(input string tag, input int sel, input int per_q[$], input int lead,
                           input int extra_start_at, input bit start_given,
                           input bit start_on_done, output int done_cyc);
        bit          wave[$];
        bit          cut, busy_ok;
        int          limit, w, h, budget;
        logic        o_busy, o_done, o_tmo, e_tmo;
        logic [63:0] o_sum, o_min, o_max, e_sum, e_min, e_max;

        limit = (sel == 0) ? TMO_A : TMO_B;
        w     = (sel == 0) ? W_A : W_B;
        cut   = 1'b0;
        repeat (lead) wave.push_back(1'b0);
        foreach (per_q[i]) begin
            h = per_q[i] / 2;
            repeat (h) wave.push_back(1'b1);
            repeat (per_q[i] - h) wave.push_back(1'b0);
            if (per_q[i] > limit) begin
                cut = 1'b1;
                break;
            end
        end
        if (per_q.size() > 0 && !cut) begin
            wave.push_back(1'b1);
            wave.push_back(1'b0);
        end

        budget   = wave.size() + limit + 20;
        done_cyc = -1;
        busy_ok  = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (!(c == 0 && start_given)) @(negedge clk);
            if (c > 0) begin
                sample(sel, o_busy, o_done, o_tmo, o_sum, o_min, o_max);
                if (c == 1) begin
                    check({tag, " cleared sum"}, o_sum, 0);
                    check({tag, " cleared min"}, o_min, all_ones(w));
                    check({tag, " cleared max"}, o_max, 0);
                    check({tag, " cleared timeout"}, 64'(o_tmo), 0);
                    check({tag, " done low at start"}, 64'(o_done), 0);
                end
                if (o_done) begin
                    done_cyc = c - 1;
                    check({tag, " busy low on done"}, 64'(o_busy), 0);
                    drive(sel, 1'b0, start_on_done);
                    break;
                end
                if (!o_busy) busy_ok = 1'b0;
            end
            drive(sel, (c < wave.size()) ? wave[c] : 1'b0, (c == 0) || (c == extra_start_at));
        end

        if (done_cyc < 0) begin
            check({tag, " done within budget"}, 0, 1);
            drive(sel, 1'b0, 1'b0);
        end
        check({tag, " busy throughout run"}, 64'(busy_ok), 1);

        model(per_q, w, limit, e_sum, e_min, e_max, e_tmo);
        sample(sel, o_busy, o_done, o_tmo, o_sum, o_min, o_max);
        check({tag, " sum"}, o_sum, e_sum);
        check({tag, " min"}, o_min, e_min);
        check({tag, " max"}, o_max, e_max);
        check({tag, " timeout"}, 64'(o_tmo), 64'(e_tmo));
    endtask

    task automatic check_reset_state(input string tag, input int sel);
        logic        o_busy, o_done, o_tmo;
        logic [63:0] o_sum, o_min, o_max;
        sample(sel, o_busy, o_done, o_tmo, o_sum, o_min, o_max);
        check({tag, " busy"}, 64'(o_busy), 0);
        check({tag, " done"}, 64'(o_done), 0);
        check({tag, " timeout"}, 64'(o_tmo), 0);
        check({tag, " sum"}, o_sum, 0);
        check({tag, " min"}, o_min, all_ones(sel == 0 ? W_A : W_B));
        check({tag, " max"}, o_max, 0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int q[$];
        int dc;
        int done_seen;
        int p;

        clk_reset_n = 1'b0;
        sig_a = 1'b0; start_a = 1'b0; sig_b = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset a", 0);
        check_reset_state("reset b", 1);
        clk_reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Run 1: 10-cycle square wave.
        q = '{10, 10, 10, 10};
        measure("run1", 0, q, 2, -1, 1'b0, 1'b0, dc);
        repeat (3) @(negedge clk);

        // Run 2: unequal periods.
        q = '{10, 12, 8, 14};
        measure("run2", 0, q, 3, -1, 1'b0, 1'b0, dc);
        repeat (3) @(negedge clk);

        // Run 3: no edges at all; timeout counted from ARM entry.
        q.delete();
        measure("run3", 0, q, 0, -1, 1'b0, 1'b0, dc);
        check("run3 done latency", 64'(dc), 64'(TMO_A));
        repeat (3) @(negedge clk);

        // Run 4: start while busy is ignored; start on the done cycle restarts.
        q = '{10, 10, 10, 10};
        measure("run4a", 0, q, 2, 20, 1'b0, 1'b1, dc);
        q = '{6, 7, 9, 11};
        measure("run4b", 0, q, 2, -1, 1'b1, 1'b0, dc);
        repeat (3) @(negedge clk);

        // Boundary: a period equal to the timeout is accepted.
        q = '{100, 100, 100, 100};
        measure("tmo_edge", 0, q, 1, -1, 1'b0, 1'b0, dc);
        repeat (3) @(negedge clk);

        // Boundary: one cycle longer aborts with the completed period only.
        q = '{20, 101, 10, 10};
        measure("tmo_over", 0, q, 1, -1, 1'b0, 1'b0, dc);
        repeat (3) @(negedge clk);

        // Run 5: reset in the middle of MEAS.
        @(negedge clk);
        start_a = 1'b1;
        sig_a   = 1'b0;
        for (int c = 1; c < 30; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            sig_a   = (c >= 2) && (((c - 2) % 10) < 5);
        end
        @(negedge clk);
        check("run5 busy before reset", 64'(busy_a), 1);
        clk_reset_n = 1'b0;
        sig_a       = 1'b0;
        #1;
        check_reset_state("run5 in reset", 0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_a) done_seen++;
        end
        clk_reset_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done_a || busy_a) done_seen++;
        end
        check("run5 no done after reset", 64'(done_seen), 0);
        q = '{10, 10, 10, 10};
        measure("run5 after", 0, q, 2, -1, 1'b0, 1'b0, dc);
        repeat (3) @(negedge clk);

        // Run 6: narrow instance, sum saturates.
        q = '{100, 100, 100, 100};
        measure("run6", 1, q, 2, -1, 1'b0, 1'b0, dc);
        repeat (3) @(negedge clk);

        // Randomised runs on the wide instance, some crossing the timeout.
        for (int r = 0; r < 40; r++) begin
            q.delete();
            for (int i = 0; i < NUM; i++) begin
                p = ($urandom_range(0, 5) == 0) ? int'($urandom_range(90, 110))
                                                : int'($urandom_range(2, 40));
                q.push_back(p);
            end
            measure($sformatf("rand_a%0d", r), 0, q, int'($urandom_range(0, 5)), -1,
                    1'b0, ($urandom_range(0, 3) == 0), dc);
            if (start_a) begin
                // Started on done: run the follow-up directly.
                q.delete();
                for (int i = 0; i < NUM; i++) q.push_back(int'($urandom_range(2, 30)));
                measure($sformatf("rand_a%0d_re", r), 0, q, 1, -1, 1'b1, 1'b0, dc);
            end
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        // Randomised runs on the narrow instance.
        for (int r = 0; r < 10; r++) begin
            q.delete();
            for (int i = 0; i < NUM; i++) q.push_back(int'($urandom_range(40, 200)));
            measure($sformatf("rand_b%0d", r), 1, q, int'($urandom_range(0, 5)), -1,
                    1'b0, 1'b0, dc);
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
